bernoulli_rate_estimator: RTL and testbench
===========================================

// Module: bernoulli_rate_estimator
// PURPOSE
//   Receive-side counterpart of the bernoulli generators. Recovers the
//   per-channel probability (threshold) from OUTPUTS parallel Bernoulli bit
//   streams by counting ones over a fixed window of 2^WINDOW_LOG2 accepted
//   samples. Reports the result in the generator's threshold scale
//   (probability * 2^WIDTH). Used for closed-loop calibration of generators
//   and for spike-rate readout in the TNN column.
// PARAMETERS
//   INPUTS       4   number of parallel bit streams
//   WIDTH        7   estimate width; matches generator threshold width
//   WINDOW_LOG2  7   window = 2^WINDOW_LOG2 samples; must be >= WIDTH (elaboration check)
// PORTS
//   clk        in   1               clock
//   rst_n      in   1               synchronous active-low reset
//   start      in   1               begin a window (sampled in IDLE only)
//   cont       in   1               on window end, restart immediately
//   en         in   1               in[] valid this cycle; counted only in COUNT
//   in         in   [0:INPUTS-1]    Bernoulli bits, one per channel
//   est        out  [0:INPUTS-1][WIDTH-1:0]  latched estimate per channel
//   est_valid  out  1               one-cycle pulse; est updated this cycle
//   busy       out  1               high while in COUNT
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge): state=IDLE; est=0; est_valid=0; busy=0;
//     all counters 0. Reset mid-window discards the partial window and
//     leaves no pending est_valid.
//   - States: IDLE, COUNT, DONE.
//     IDLE : start=1 -> COUNT; sample counter and ones counters cleared.
//     COUNT: en=1 -> sample_cnt+=1, ones[i]+=in[i]. When the accepted
//            sample is number 2^WINDOW_LOG2 -> DONE. en=0 cycles are ignored
//            and do not advance. start is ignored in COUNT.
//     DONE : one cycle. est registered, est_valid=1. Next state is COUNT
//            with cleared counters if cont=1, else IDLE. In is not sampled
//            in DONE; the next window begins on the following cycle.
//   - Latency: est_valid rises on the cycle after the posedge that accepted
//     the last sample of the window.
//   - Counters: sample_cnt and ones[i] are WINDOW_LOG2+1 bits wide, so they
//     hold 2^WINDOW_LOG2 without wrap.
//   - Estimate: est[i] = ones[i] >> (WINDOW_LOG2-WIDTH), saturated to
//     2^WIDTH-1. An all-ones window gives 2^WIDTH-1 and never wraps to 0.
//   - est holds its value between windows and is not cleared by start.
//   - busy = (state==COUNT). est_valid is 0 outside DONE.
// TESTING
//   1. Defaults. start pulse, 128 cycles en=1 with in=4'b1111 -> est={127,127,127,127}
//      and est_valid is a single pulse on cycle 129 after start is accepted.
//   2. in=4'b0000 for one window -> est=0 on all channels; busy is low after DONE.
//   3. Defaults. ch0 alternates 1/0, ch1 is 1 every 4th sample, ch2=1, ch3=0
//      -> est={64,32,127,0}.
//   4. en toggled 50% over the same stimulus -> identical est; est_valid comes
//      after 256 cycles. A start pulse mid-COUNT has no effect.
//   5. WINDOW_LOG2=10, fed by bernoulli_dynamic thresholds {32,64,96,127},
//      cont=1 for 4 windows -> est_valid every 1025 cycles; each est within
//      +/-6 of its threshold (127 tolerance one-sided).
//   6. rst_n low for one cycle at sample 60 -> est=0, no est_valid, IDLE.
//      A new start then produces a correct full window.

Source files
------------

// File: rtl/bernoulli_rate_estimator.sv
// Windowed ones-counter that recovers per-channel Bernoulli probability in the
// generator threshold scale (probability * 2^WIDTH), one estimate per window.
module bernoulli_rate_estimator #(
  parameter int unsigned INPUTS      = 4,
  parameter int unsigned WIDTH       = 7,
  parameter int unsigned WINDOW_LOG2 = 7
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          cont,
  input  logic                          en,
  input  logic [0:INPUTS-1]             in,
  output logic [0:INPUTS-1][WIDTH-1:0]  est,
  output logic                          est_valid,
  output logic                          busy
);

  localparam int unsigned   CW          = WINDOW_LOG2 + 1;
  localparam int unsigned   SHIFT       = WINDOW_LOG2 - WIDTH;
  localparam logic [CW-1:0] LAST_SAMPLE = {1'b0, {WINDOW_LOG2{1'b1}}};
  localparam logic [CW-1:0] EST_MAX     = {{(CW-WIDTH){1'b0}}, {WIDTH{1'b1}}};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  if (WINDOW_LOG2 < WIDTH) begin : g_bad_cfg
    $error("bernoulli_rate_estimator: WINDOW_LOG2 must be >= WIDTH");
  end

  logic [1:0]                    state_q, state_d;
  logic [CW-1:0]                 sample_cnt_q, sample_cnt_d;
  logic [CW-1:0]                 ones_q [INPUTS];
  logic [CW-1:0]                 ones_d [INPUTS];
  logic [0:INPUTS-1][WIDTH-1:0]  est_q, est_d;
  logic                          est_valid_q, est_valid_d;

  // A full window of ones scales to exactly 2^WIDTH, so clamp instead of wrapping.
  function automatic logic [WIDTH-1:0] scale_sat(input logic [CW-1:0] ones);
    logic [CW-1:0] shifted;
    shifted = ones >> SHIFT;
    if (shifted > EST_MAX) scale_sat = '1;
    else                   scale_sat = shifted[WIDTH-1:0];
  endfunction

  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    ones_d       = ones_q;
    est_d        = est_q;
    est_valid_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_COUNT;
          sample_cnt_d = '0;
          for (int unsigned i = 0; i < INPUTS; i++) ones_d[i] = '0;
        end
      end
      S_COUNT: begin
        if (en) begin
          sample_cnt_d = sample_cnt_q + 1'b1;
          for (int unsigned i = 0; i < INPUTS; i++) ones_d[i] = ones_q[i] + CW'(in[i]);
          // Latch from the updated counts so the last sample is included.
          if (sample_cnt_q == LAST_SAMPLE) begin
            state_d     = S_DONE;
            est_valid_d = 1'b1;
            for (int unsigned i = 0; i < INPUTS; i++) est_d[i] = scale_sat(ones_d[i]);
          end
        end
      end
      S_DONE: begin
        sample_cnt_d = '0;
        for (int unsigned i = 0; i < INPUTS; i++) ones_d[i] = '0;
        state_d = cont ? S_COUNT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sample_cnt_q <= '0;
      for (int unsigned i = 0; i < INPUTS; i++) ones_q[i] <= '0;
      est_q        <= '0;
      est_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      for (int unsigned i = 0; i < INPUTS; i++) ones_q[i] <= ones_d[i];
      est_q        <= est_d;
      est_valid_q  <= est_valid_d;
    end
  end

  assign est       = est_q;
  assign est_valid = est_valid_q;
  assign busy      = (state_q == S_COUNT);

endmodule

// File: tb/tb_bernoulli_rate_estimator.sv
// Scoreboard bench for bernoulli_rate_estimator: a 128-sample instance and a
// 1024-sample instance running back-to-back windows.
module tb_bernoulli_rate_estimator;

  typedef logic [0:3][6:0] est_vec_t;

  logic clk;
  logic rst_n;
  logic start_a, cont_a, en_a;
  logic [0:3] in_a;
  est_vec_t est_a;
  logic est_valid_a, busy_a;
  logic start_b, cont_b, en_b;
  logic [0:3] in_b;
  est_vec_t est_b;
  logic est_valid_b, busy_b;

  int checks = 0;
  int errors = 0;
  est_vec_t exp_q[$];
  est_vec_t last_est;

  bernoulli_rate_estimator #(.INPUTS(4), .WIDTH(7), .WINDOW_LOG2(7)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .cont(cont_a), .en(en_a),
    .in(in_a), .est(est_a), .est_valid(est_valid_a), .busy(busy_a)
  );

  bernoulli_rate_estimator #(.INPUTS(4), .WIDTH(7), .WINDOW_LOG2(10)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .cont(cont_b), .en(en_b),
    .in(in_b), .est(est_b), .est_valid(est_valid_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] exp_est(input int ones, input int wl2);
    int v;
    v = ones >> (wl2 - 7);
    if (v > 127) v = 127;
    return v[6:0];
  endfunction

  function automatic logic pattern_bit(input int mode, input int ch, input int k);
    case (mode)
      0: return 1'b1;
      1: return 1'b0;
      default: begin
        case (ch)
          0: return (k % 2) == 0;
          1: return (k % 4) == 0;
          2: return 1'b1;
          default: return 1'b0;
        endcase
      end
    endcase
  endfunction

  // Drives one 128-sample window into DUT A (start already accepted); the
  // expected estimate goes to the scoreboard when the last sample is driven.
  task automatic feed_window(input int mode, input bit gaps, input bit mid_start,
                             output int edges, output int early);
    int ones[4];
    est_vec_t e;
    for (int c = 0; c < 4; c++) ones[c] = 0;
    edges = 0;
    early = 0;
    for (int k = 0; k < 128; k++) begin
      if (gaps) begin
        en_a = 1'b0;
        in_a = 4'($urandom);
        start_a = mid_start && (k == 40);
        cyc();
        edges++;
        start_a = 1'b0;
        if (est_valid_a || !busy_a) early++;
      end
      en_a = 1'b1;
      for (int c = 0; c < 4; c++) begin
        in_a[c] = pattern_bit(mode, c, k);
        ones[c] += int'(in_a[c]);
      end
      if (k == 127) begin
        for (int c = 0; c < 4; c++) e[c] = exp_est(ones[c], 7);
        exp_q.push_back(e);
      end
      cyc();
      edges++;
      if (k < 127 && (est_valid_a || !busy_a)) early++;
    end
    en_a = 1'b0;
    in_a = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_a = 0; cont_a = 0; en_a = 0; in_a = '0;
    start_b = 0; cont_b = 0; en_b = 0; in_b = '0;
    cyc(); cyc();
    checks++; if (est_a !== '0) begin errors++; $display("FAIL reset_est: got %h expected 0", est_a); end
    checks++; if (est_valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", est_valid_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    checks++; if (busy_b !== 1'b0 || est_valid_b !== 1'b0 || est_b !== '0)
      begin errors++; $display("FAIL reset_b: got busy=%b valid=%b est=%h expected 0/0/0", busy_b, est_valid_b, est_b); end
    rst_n = 1'b1;
    en_a = 1'b1;
    cyc(); cyc();
    en_a = 1'b0;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL idle_no_start: busy got %b expected 0", busy_a); end
  endtask

  task automatic check_window(input string name, input int edges, input int exp_edges, input int early);
    est_vec_t e;
    checks++; if (est_valid_a !== 1'b1) begin errors++; $display("FAIL %s_valid: got %b expected 1", name, est_valid_a); end
    checks++; if (edges != exp_edges) begin errors++; $display("FAIL %s_latency: got %0d edges expected %0d", name, edges, exp_edges); end
    checks++; if (early != 0) begin errors++; $display("FAIL %s_early: got %0d bad cycles expected 0", name, early); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL %s_sb: got empty scoreboard expected entry", name); end
    else begin
      e = exp_q.pop_front();
      last_est = e;
      if (est_a !== e) begin errors++; $display("FAIL %s_est: got %h expected %h", name, est_a, e); end
    end
    cyc();
    checks++; if (est_valid_a !== 1'b0) begin errors++; $display("FAIL %s_pulse: got %b expected 0", name, est_valid_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL %s_busy_after: got %b expected 0", name, busy_a); end
  endtask

  task automatic test_all_ones();
    int edges, early;
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL ones_busy: got %b expected 1", busy_a); end
    feed_window(0, 1'b0, 1'b0, edges, early);
    check_window("ones", edges, 128, early);
    checks++; if (last_est !== {4{7'd127}}) begin errors++; $display("FAIL ones_sat: got %h expected all 7f", est_a); end
  endtask

  task automatic test_zero_window();
    int edges, early;
    repeat (5) cyc();
    checks++; if (est_a !== last_est) begin errors++; $display("FAIL hold_idle: got %h expected %h", est_a, last_est); end
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    checks++; if (est_a !== last_est) begin errors++; $display("FAIL hold_start: got %h expected %h", est_a, last_est); end
    feed_window(1, 1'b0, 1'b0, edges, early);
    check_window("zero", edges, 128, early);
  endtask

  task automatic test_pattern(input bit gaps);
    int edges, early;
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    feed_window(2, gaps, gaps, edges, early);
    check_window(gaps ? "gaps" : "pattern", edges, gaps ? 256 : 128, early);
    checks++; if (est_a !== {7'd64, 7'd32, 7'd127, 7'd0})
      begin errors++; $display("FAIL %s_const: got %h expected {64,32,127,0}", gaps ? "gaps" : "pattern", est_a); end
  endtask

  task automatic test_cont_long();
    int thr[4] = '{32, 64, 96, 127};
    int g = 0;
    int tot = 0;
    int last_valid = 0;
    int bad = 0;
    int ones[4];
    est_vec_t e;
    cont_b = 1'b1;
    en_b = 1'b1;
    start_b = 1'b1;
    cyc();
    start_b = 1'b0;
    for (int w = 0; w < 4; w++) begin
      for (int c = 0; c < 4; c++) ones[c] = 0;
      for (int k = 0; k < 1024; k++) begin
        for (int c = 0; c < 4; c++) begin
          in_b[c] = ((g * 77) % 128) < thr[c];
          ones[c] += int'(in_b[c]);
        end
        g++;
        if (k == 1023) begin
          for (int c = 0; c < 4; c++) e[c] = exp_est(ones[c], 10);
          exp_q.push_back(e);
        end
        cyc();
        tot++;
        if (k < 1023 && (est_valid_b || !busy_b)) bad++;
      end
      checks++; if (est_valid_b !== 1'b1) begin errors++; $display("FAIL cont_valid_w%0d: got %b expected 1", w, est_valid_b); end
      checks++; if (tot - last_valid != (w == 0 ? 1024 : 1025))
        begin errors++; $display("FAIL cont_period_w%0d: got %0d expected %0d", w, tot - last_valid, (w == 0 ? 1024 : 1025)); end
      last_valid = tot;
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL cont_sb_w%0d: got empty scoreboard expected entry", w); end
      else begin
        e = exp_q.pop_front();
        if (est_b !== e) begin errors++; $display("FAIL cont_est_w%0d: got %h expected %h", w, est_b, e); end
      end
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (int'(est_b[c]) > thr[c] + 6 || int'(est_b[c]) < thr[c] - 6)
          begin errors++; $display("FAIL cont_tol_w%0d_ch%0d: got %0d expected %0d +/-6", w, c, est_b[c], thr[c]); end
      end
      in_b = '1;
      cont_b = (w < 3);
      cyc();
      tot++;
      checks++; if (est_valid_b !== 1'b0 || busy_b !== (w < 3))
        begin errors++; $display("FAIL cont_done_w%0d: got valid=%b busy=%b expected 0/%b", w, est_valid_b, busy_b, (w < 3)); end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL cont_midwindow: got %0d bad cycles expected 0", bad); end
    en_b = 1'b0;
    in_b = '0;
  endtask

  task automatic test_reset_mid_window();
    int bad = 0;
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    en_a = 1'b1;
    in_a = 4'b1111;
    repeat (60) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    checks++; if (est_a !== '0) begin errors++; $display("FAIL rstmid_est: got %h expected 0", est_a); end
    checks++; if (est_valid_a !== 1'b0 || busy_a !== 1'b0)
      begin errors++; $display("FAIL rstmid_state: got valid=%b busy=%b expected 0/0", est_valid_a, busy_a); end
    for (int i = 0; i < 140; i++) begin
      cyc();
      if (est_valid_a || busy_a) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_idle: got %0d active cycles expected 0", bad); end
    en_a = 1'b0;
    in_a = '0;
    test_pattern(1'b0);
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_zero_window();
    test_pattern(1'b0);
    test_pattern(1'b1);
    test_cont_long();
    test_reset_mid_window();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
